// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared definitions for the operand forwarding / hazard unit: default widths,
// writeback-history entry layout, stall FSM encoding and counter helper.
package forwarding_hazard_unit_pkg;

    localparam int unsigned DEF_DATA_WIDTH       = 32;
    localparam int unsigned DEF_REG_ADDR_WIDTH   = 5;
    localparam int unsigned DEF_NUM_READ_PORTS   = 2;
    localparam int unsigned DEF_NUM_SOURCES      = 2;
    localparam int unsigned DEF_WB_HISTORY_DEPTH = 1;
    localparam int unsigned CNT_WIDTH            = 16;

    typedef struct packed {
        logic                          valid;
        logic [DEF_REG_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0]     data;
    } wb_entry_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } fsm_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/forwarding_hazard_unit_operand_mux.sv
// Single-operand resolver: picks the newest producer of one source register
// and flags a hazard when that producer's result is still in flight.
module forwarding_operand_mux
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH   = DEF_REG_ADDR_WIDTH,
    parameter int unsigned NUM_SOURCES      = DEF_NUM_SOURCES,
    parameter int unsigned WB_HISTORY_DEPTH = DEF_WB_HISTORY_DEPTH
) (
    input  logic [REG_ADDR_WIDTH-1:0]                  i_rs_addr,
    input  logic                                       i_rs_used,
    input  logic [DATA_WIDTH-1:0]                      i_rs_value,
    input  logic [NUM_SOURCES-1:0]                     i_src_valid,
    input  logic [NUM_SOURCES*REG_ADDR_WIDTH-1:0]      i_src_rd,
    input  logic [NUM_SOURCES-1:0]                     i_src_data_ready,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0]          i_src_data,
    input  logic [WB_HISTORY_DEPTH-1:0]                i_hist_valid,
    input  logic [WB_HISTORY_DEPTH*REG_ADDR_WIDTH-1:0] i_hist_addr,
    input  logic [WB_HISTORY_DEPTH*DATA_WIDTH-1:0]     i_hist_data,
    output logic [DATA_WIDTH-1:0]                      o_value,
    output logic                                       o_hazard
);

    logic w_found;

    // Pipeline sources first (index 0 youngest), then history newest-first;
    // the first hit wins, so an older ready copy can never hide a pending load.
    always_comb begin
        o_value  = i_rs_value;
        o_hazard = 1'b0;
        w_found  = 1'b0;
        if (i_rs_used) begin
            if (i_rs_addr == '0) begin
                o_value = '0;
            end else begin
                for (int s = 0; s < int'(NUM_SOURCES); s++) begin
                    if (!w_found && i_src_valid[s] &&
                        i_src_rd[s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == i_rs_addr) begin
                        w_found  = 1'b1;
                        o_value  = i_src_data[s*DATA_WIDTH +: DATA_WIDTH];
                        o_hazard = !i_src_data_ready[s];
                    end
                end
                for (int h = 0; h < int'(WB_HISTORY_DEPTH); h++) begin
                    if (!w_found && i_hist_valid[h] &&
                        i_hist_addr[h*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == i_rs_addr) begin
                        w_found = 1'b1;
                        o_value = i_hist_data[h*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding and load-use hazard unit with RUN/STALL tracking.
// Define FORWARDING_PERF_COUNTERS_EN to build the stall performance counters.
module forwarding_hazard_unit
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH   = DEF_REG_ADDR_WIDTH,
    parameter int unsigned NUM_READ_PORTS   = DEF_NUM_READ_PORTS,
    parameter int unsigned NUM_SOURCES      = DEF_NUM_SOURCES,
    parameter int unsigned WB_HISTORY_DEPTH = DEF_WB_HISTORY_DEPTH
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] req_rs_addr,
    input  logic [NUM_READ_PORTS-1:0]                req_rs_used,
    input  logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     req_rs_value,
    input  logic [NUM_SOURCES-1:0]                   src_valid,
    input  logic [NUM_SOURCES*REG_ADDR_WIDTH-1:0]    src_rd,
    input  logic [NUM_SOURCES-1:0]                   src_data_ready,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0]        src_data,
    input  logic                                     wb_enable,
    input  logic [REG_ADDR_WIDTH-1:0]                wb_address,
    input  logic [DATA_WIDTH-1:0]                    wb_data,
    input  logic                                     flush,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     fwd_value,
    output logic                                     stall_active,
    output logic [CNT_WIDTH-1:0]                     stall_cycles,
    output logic [CNT_WIDTH-1:0]                     stall_events
);

    localparam int unsigned HIST_AW = WB_HISTORY_DEPTH * REG_ADDR_WIDTH;
    localparam int unsigned HIST_DW = WB_HISTORY_DEPTH * DATA_WIDTH;

    logic [WB_HISTORY_DEPTH-1:0] r_hist_valid;
    logic [HIST_AW-1:0]          r_hist_addr;
    logic [HIST_DW-1:0]          r_hist_data;
    logic [NUM_READ_PORTS-1:0]   w_port_hazard;
    logic                        w_hazard;
    logic                        w_wb_push;
    fsm_state_e                  r_state;
    fsm_state_e                  w_next_state;

    genvar p;
    generate
        for (p = 0; p < int'(NUM_READ_PORTS); p++) begin : g_port
            forwarding_operand_mux #(
                .DATA_WIDTH      (DATA_WIDTH),
                .REG_ADDR_WIDTH  (REG_ADDR_WIDTH),
                .NUM_SOURCES     (NUM_SOURCES),
                .WB_HISTORY_DEPTH(WB_HISTORY_DEPTH)
            ) u_mux (
                .i_rs_addr       (req_rs_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
                .i_rs_used       (req_rs_used[p]),
                .i_rs_value      (req_rs_value[p*DATA_WIDTH +: DATA_WIDTH]),
                .i_src_valid     (src_valid),
                .i_src_rd        (src_rd),
                .i_src_data_ready(src_data_ready),
                .i_src_data      (src_data),
                .i_hist_valid    (r_hist_valid),
                .i_hist_addr     (r_hist_addr),
                .i_hist_data     (r_hist_data),
                .o_value         (fwd_value[p*DATA_WIDTH +: DATA_WIDTH]),
                .o_hazard        (w_port_hazard[p])
            );
        end
    endgenerate

    assign w_hazard  = |w_port_hazard;
    assign req_ready = !(req_valid && w_hazard);
    assign w_wb_push = wb_enable && (wb_address != '0);

    // Retired-write history, entry 0 in the low bits; shifting drops the oldest.
    // Flush leaves it alone because these writes are already committed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist_valid <= '0;
            r_hist_addr  <= '0;
            r_hist_data  <= '0;
        end else if (w_wb_push) begin
            r_hist_valid <= (r_hist_valid << 1) | WB_HISTORY_DEPTH'(1);
            r_hist_addr  <= (r_hist_addr << REG_ADDR_WIDTH) | HIST_AW'(wb_address);
            r_hist_data  <= (r_hist_data << DATA_WIDTH) | HIST_DW'(wb_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flush overrides a simultaneous hazard.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (!flush && req_valid && w_hazard) begin
                    w_next_state = ST_STALL;
                end
            end
            ST_STALL: begin
                if (flush || !(req_valid && w_hazard)) begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    assign stall_active = (r_state == ST_STALL);

`ifdef FORWARDING_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic [CNT_WIDTH-1:0] r_stall_events;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_stall_events <= '0;
        end else begin
            if (r_state == ST_STALL) begin
                r_stall_cycles <= sat_inc(r_stall_cycles);
            end
            if (r_state == ST_RUN && w_next_state == ST_STALL) begin
                r_stall_events <= sat_inc(r_stall_events);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign stall_events = r_stall_events;
`else
    assign stall_cycles = '0;
    assign stall_events = '0;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Self-checking bench for forwarding_hazard_unit: fixed vector table, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_forwarding_hazard_unit;
    import forwarding_hazard_unit_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 2;
    localparam int NS = 2;
    localparam int HD = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [NP*AW-1:0] req_rs_addr;
    logic [NP-1:0]    req_rs_used;
    logic [NP*DW-1:0] req_rs_value;
    logic [NS-1:0]    src_valid;
    logic [NS*AW-1:0] src_rd;
    logic [NS-1:0]    src_data_ready;
    logic [NS*DW-1:0] src_data;
    logic             wb_enable;
    logic [AW-1:0]    wb_address;
    logic [DW-1:0]    wb_data;
    logic             flush;
    logic [NP*DW-1:0] fwd_value;
    logic             stall_active;
    logic [15:0]      stall_cycles;
    logic [15:0]      stall_events;

    forwarding_hazard_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_rs_addr(req_rs_addr), .req_rs_used(req_rs_used), .req_rs_value(req_rs_value),
        .src_valid(src_valid), .src_rd(src_rd), .src_data_ready(src_data_ready),
        .src_data(src_data), .wb_enable(wb_enable), .wb_address(wb_address),
        .wb_data(wb_data), .flush(flush), .fwd_value(fwd_value),
        .stall_active(stall_active), .stall_cycles(stall_cycles), .stall_events(stall_events)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: retired writes newest-first, stall flag, counters.
    wb_entry_t m_hist[$];
    bit        m_stall;
    int        m_cycles;
    int        m_events;

    typedef struct {
        logic [4:0]  a0, a1;
        logic [1:0]  used;
        logic [31:0] v0, v1;
        logic [1:0]  sv;
        logic [4:0]  rd0, rd1;
        logic [1:0]  rdy;
        logic [31:0] d0, d1;
        logic        rv;
        logic [31:0] e0, e1;
        logic        er;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Newest-producer lookup over candidates ordered youngest to oldest.
    function automatic void model_port(input int p, output logic [31:0] v, output bit hz);
        logic [4:0] a;
        bit         found;
        a     = req_rs_addr[p*AW +: AW];
        v     = req_rs_value[p*DW +: DW];
        hz    = 1'b0;
        found = 1'b0;
        if (!req_rs_used[p]) return;
        if (a == 0) begin
            v = 32'd0;
            return;
        end
        for (int s = 0; s < NS; s++) begin
            if (!found && src_valid[s] && src_rd[s*AW +: AW] == a) begin
                found = 1'b1;
                v     = src_data[s*DW +: DW];
                hz    = !src_data_ready[s];
            end
        end
        foreach (m_hist[h]) begin
            if (!found && m_hist[h].valid && m_hist[h].addr == a) begin
                found = 1'b1;
                v     = m_hist[h].data;
            end
        end
    endfunction

    function automatic bit model_hazard();
        logic [31:0] v;
        bit hz;
        bit any;
        any = 1'b0;
        for (int p = 0; p < NP; p++) begin
            model_port(p, v, hz);
            any |= hz;
        end
        return any;
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] v;
        bit hz;
        for (int p = 0; p < NP; p++) begin
            model_port(p, v, hz);
            chk($sformatf("%s fwd[%0d]", tag, p), fwd_value[p*DW +: DW], v);
        end
        chk({tag, " req_ready"}, 32'(req_ready), 32'(!(req_valid && model_hazard())));
        chk({tag, " stall_active"}, 32'(stall_active), 32'(m_stall));
`ifdef FORWARDING_PERF_COUNTERS_EN
        chk({tag, " stall_cycles"}, 32'(stall_cycles), 32'(m_cycles));
        chk({tag, " stall_events"}, 32'(stall_events), 32'(m_events));
`else
        chk({tag, " stall_cycles"}, 32'(stall_cycles), 32'd0);
        chk({tag, " stall_events"}, 32'(stall_events), 32'd0);
`endif
    endtask

    task automatic model_clock();
        bit        nxt;
        wb_entry_t e;
        nxt = !flush && req_valid && model_hazard();
        if (m_stall && m_cycles < 16'hFFFF) m_cycles++;
        if (!m_stall && nxt && m_events < 16'hFFFF) m_events++;
        if (wb_enable && wb_address != 0) begin
            e.valid = 1'b1;
            e.addr  = wb_address;
            e.data  = wb_data;
            m_hist.push_front(e);
            if (m_hist.size() > HD) void'(m_hist.pop_back());
        end
        m_stall = nxt;
    endtask

    // Inputs are set just after an edge; check mid-cycle, then advance.
    task automatic cycle(input string tag);
        #2;
        check_all(tag);
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_stall  = 1'b0;
        m_cycles = 0;
        m_events = 0;
    endtask

    task automatic clear_inputs();
        req_valid = 0; req_rs_addr = '0; req_rs_used = '0; req_rs_value = '0;
        src_valid = '0; src_rd = '0; src_data_ready = '1; src_data = '0;
        wb_enable = 0; wb_address = '0; wb_data = '0; flush = 0;
    endtask

    // src0 writes r7 with result pending when 'on'; rs2 consumes r7.
    task automatic set_hazard(input bit on);
        clear_inputs();
        req_valid = 1;
        src_valid = 2'b01; src_rd[4:0] = 5'd7; src_data_ready[0] = !on; src_data[31:0] = 32'h7777;
        req_rs_addr[9:5] = 5'd7; req_rs_used = 2'b10; req_rs_value[63:32] = 32'h0BAD;
    endtask

    task automatic do_reset();
        rst = 1;
        #3;
        model_reset();
        rst = 0;
        #1;
    endtask

    function automatic vec_t mkvec(
        input logic [4:0] a0, a1, input logic [1:0] used, input logic [31:0] v0, v1,
        input logic [1:0] sv, input logic [4:0] rd0, rd1, input logic [1:0] rdy,
        input logic [31:0] d0, d1, input logic rv, input logic [31:0] e0, e1, input logic er);
        vec_t t;
        t.a0 = a0; t.a1 = a1; t.used = used; t.v0 = v0; t.v1 = v1; t.sv = sv;
        t.rd0 = rd0; t.rd1 = rd1; t.rdy = rdy; t.d0 = d0; t.d1 = d1; t.rv = rv;
        t.e0 = e0; t.e1 = e1; t.er = er;
        return t;
    endfunction

    initial begin
        clear_inputs();
        model_reset();
        rst = 1;
        #12;
        check_all("reset");
        chk("reset stall_active", 32'(stall_active), 32'd0);
        rst = 0;

        //                a0 a1 used v0        v1        sv    rd0 rd1 rdy   d0          d1       rv e0         e1        er
        vecs[0] = mkvec(5, 9, 2'b11, 32'hAAAA, 32'hBBBB, 2'b11, 5, 5, 2'b11, 32'h11,   32'h22,   1, 32'h11,   32'hBBBB, 1);
        vecs[1] = mkvec(5, 6, 2'b11, 32'hAAAA, 32'hBBBB, 2'b10, 5, 5, 2'b11, 32'h11,   32'h22,   1, 32'h22,   32'hBBBB, 1);
        vecs[2] = mkvec(0, 0, 2'b01, 32'h1234, 32'h55,   2'b01, 0, 0, 2'b00, 32'hFFFF, 32'h0,    1, 32'h0,    32'h55,   1);
        vecs[3] = mkvec(5, 6, 2'b11, 32'h1,    32'h2,    2'b11, 5, 6, 2'b11, 32'hC0DE, 32'hBEEF, 1, 32'hC0DE, 32'hBEEF, 1);
        vecs[4] = mkvec(5, 6, 2'b00, 32'h3,    32'h4,    2'b11, 5, 6, 2'b00, 32'h9,    32'hA,    1, 32'h3,    32'h4,    1);
        vecs[5] = mkvec(5, 0, 2'b01, 32'h3,    32'h4,    2'b11, 5, 5, 2'b10, 32'h9,    32'hA,    1, 32'h9,    32'h4,    0);
        vecs[6] = mkvec(5, 0, 2'b01, 32'h3,    32'h4,    2'b11, 5, 5, 2'b01, 32'h9,    32'hA,    1, 32'h9,    32'h4,    1);
        vecs[7] = mkvec(5, 0, 2'b01, 32'h3,    32'h4,    2'b01, 5, 0, 2'b00, 32'h9,    32'hA,    0, 32'h9,    32'h4,    1);
        vecs[8] = mkvec(5, 6, 2'b11, 32'h3,    32'h4,    2'b00, 5, 6, 2'b00, 32'h9,    32'hA,    1, 32'h3,    32'h4,    1);

        #1;
        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            req_valid = vecs[i].rv; req_rs_addr = {vecs[i].a1, vecs[i].a0};
            req_rs_used = vecs[i].used; req_rs_value = {vecs[i].v1, vecs[i].v0};
            src_valid = vecs[i].sv; src_rd = {vecs[i].rd1, vecs[i].rd0};
            src_data_ready = vecs[i].rdy; src_data = {vecs[i].d1, vecs[i].d0};
            #1;
            chk($sformatf("vec%0d fwd0", i), fwd_value[31:0], vecs[i].e0);
            chk($sformatf("vec%0d fwd1", i), fwd_value[63:32], vecs[i].e1);
            chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].er));
            cycle($sformatf("vec%0d", i));
        end
        clear_inputs();
        cycle("idle");

        // Load-use stall then release.
        set_hazard(1);
        #1 chk("lu req_ready", 32'(req_ready), 32'd0);
        cycle("lu0");
        chk("lu stall_active", 32'(stall_active), 32'd1);
        src_data_ready[0] = 1;
        #1 chk("lu release ready", 32'(req_ready), 32'd1);
        chk("lu release fwd1", fwd_value[63:32], 32'h7777);
        cycle("lu1");
        chk("lu back to run", 32'(stall_active), 32'd0);

        // Writeback becomes visible one cycle later.
        clear_inputs();
        wb_enable = 1; wb_address = 5'd3; wb_data = 32'hABCD;
        req_rs_addr[4:0] = 5'd3; req_rs_used = 2'b01; req_rs_value[31:0] = 32'h1111;
        #1 chk("wb same cycle", fwd_value[31:0], 32'h1111);
        cycle("wb0");
        wb_enable = 0;
        #1 chk("wb visible", fwd_value[31:0], 32'hABCD);
        cycle("wb1");
        wb_enable = 1; wb_address = 5'd0; wb_data = 32'hDEAD;
        cycle("wb addr0");
        wb_enable = 0;
        #1 chk("wb addr0 not pushed", fwd_value[31:0], 32'hABCD);
        src_valid = 2'b10; src_rd[9:5] = 5'd3; src_data[63:32] = 32'h5151;
        #1 chk("src over history", fwd_value[31:0], 32'h5151);
        cycle("wb2");
        clear_inputs();
        wb_enable = 1; wb_address = 5'd4; wb_data = 32'h4444;
        cycle("wb3");
        wb_enable = 0; req_rs_addr = {5'd4, 5'd3}; req_rs_used = 2'b11; req_rs_value = {32'h2, 32'h1};
        #1 chk("hist oldest dropped", fwd_value[31:0], 32'h1);
        chk("hist newest", fwd_value[63:32], 32'h4444);
        cycle("wb4");

        // Flush out of a stall, and flush beating a hazard.
        set_hazard(1);
        cycle("fl0");
        chk("fl stalled", 32'(stall_active), 32'd1);
        flush = 1;
        cycle("fl1");
        chk("fl to run", 32'(stall_active), 32'd0);
        cycle("fl2");
        chk("fl held run", 32'(stall_active), 32'd0);
        flush = 0;

        // Asynchronous reset in the middle of a stall.
        cycle("rs0");
        chk("rs stalled", 32'(stall_active), 32'd1);
        #2 rst = 1;
        #1 chk("rs async clear", 32'(stall_active), 32'd0);
        chk("rs ready from inputs", 32'(req_ready), 32'd0);
        model_reset();
        rst = 0;
        clear_inputs();
        cycle("rs1");

        // 3-cycle stall followed by a 2-cycle stall.
        do_reset();
        for (int i = 0; i < 3; i++) begin set_hazard(1); cycle("pc a"); end
        clear_inputs(); cycle("pc b");
        for (int i = 0; i < 2; i++) begin set_hazard(1); cycle("pc c"); end
        clear_inputs(); cycle("pc d");
        cycle("pc e");
`ifdef FORWARDING_PERF_COUNTERS_EN
        chk("perf stall_cycles", 32'(stall_cycles), 32'd5);
        chk("perf stall_events", 32'(stall_events), 32'd2);
`else
        chk("perf stall_cycles off", 32'(stall_cycles), 32'd0);
        chk("perf stall_events off", 32'(stall_events), 32'd0);
`endif

        // Randomized traffic with a small address space to force collisions.
        for (int n = 0; n < 400; n++) begin
            req_valid = 1'($urandom_range(0, 3) != 0);
            for (int p = 0; p < NP; p++) begin
                req_rs_addr[p*AW +: AW]  = 5'($urandom_range(0, 7));
                req_rs_value[p*DW +: DW] = $urandom;
            end
            req_rs_used = 2'($urandom);
            for (int s = 0; s < NS; s++) begin
                src_rd[s*AW +: AW]  = 5'($urandom_range(0, 7));
                src_data[s*DW +: DW] = $urandom;
            end
            src_valid      = 2'($urandom);
            src_data_ready = 2'($urandom) | 2'($urandom);
            wb_enable      = 1'($urandom);
            wb_address     = 5'($urandom_range(0, 7));
            wb_data        = $urandom;
            flush          = 1'($urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
